// File: rtl/morse_pkg.sv
// Shared constants for the Morse key decoder: token types, FSM encoding and
// the unit-counter sizing helper.
package morse_pkg;

   localparam logic [1:0] TOK_CHAR  = 2'd0;
   localparam logic [1:0] TOK_SPACE = 2'd1;
   localparam logic [1:0] TOK_BSP   = 2'd2;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_MARK      = 2'd1;
   localparam logic [1:0] ST_GAP       = 2'd2;
   localparam logic [1:0] ST_WAIT_WORD = 2'd3;

   // Saturation point of the unit counter: the longest interval ever compared.
   function automatic int unsigned ucnt_max(input int unsigned word_gap_units,
                                            input int unsigned erase_units);
      return (word_gap_units > erase_units) ? word_gap_units : erase_units;
   endfunction

   function automatic int unsigned ucnt_width(input int unsigned word_gap_units,
                                              input int unsigned erase_units);
      return $clog2(ucnt_max(word_gap_units, erase_units) + 1);
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler for the key decoder: counts whole Morse units since the last
// key edge, saturating at the longest interval of interest.
module morse_unit_timer #(
   parameter int unsigned UNIT_CYCLES = 16,
   parameter int unsigned UCNT_MAX    = 10,
   parameter int unsigned UW          = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key,
   output logic [UW-1:0] ucnt,
   output logic          unit_tick_c,
   output logic          key_edge_c
);

   localparam int unsigned PW = $clog2(UNIT_CYCLES);

   logic          key_q, key_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [UW-1:0] ucnt_q, ucnt_d;

   // Any key edge restarts timing so each press and each gap is measured alone.
   always_comb begin
      key_d       = key;
      pcnt_d      = pcnt_q;
      ucnt_d      = ucnt_q;
      key_edge_c  = key ^ key_q;
      unit_tick_c = 1'b0;
      if (key_edge_c) begin
         pcnt_d = '0;
         ucnt_d = '0;
      end else if (pcnt_q == PW'(UNIT_CYCLES - 1)) begin
         unit_tick_c = 1'b1;
         pcnt_d      = '0;
         if (ucnt_q != UW'(UCNT_MAX)) begin
            ucnt_d = ucnt_q + UW'(1);
         end
      end else begin
         pcnt_d = pcnt_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q  <= 1'b0;
         pcnt_q <= '0;
         ucnt_q <= '0;
      end else begin
         key_q  <= key_d;
         pcnt_q <= pcnt_d;
         ucnt_q <= ucnt_d;
      end
   end

   assign ucnt = ucnt_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Straight-key Morse decoder: classifies presses into dits, dashes and erases,
// assembles characters and emits char/space/backspace tokens over valid/ready.
module morse_key_decoder
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES    = 16,
   parameter int unsigned DASH_UNITS     = 2,
   parameter int unsigned CHAR_GAP_UNITS = 3,
   parameter int unsigned WORD_GAP_UNITS = 7,
   parameter int unsigned ERASE_UNITS    = 10,
   parameter int unsigned MAX_SYM        = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       key,
   input  logic                       en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_type,
   output logic [$clog2(MAX_SYM+1)-1:0] out_len,
   output logic [MAX_SYM-1:0]         out_pattern,
   output logic                       err,
   output logic                       busy
);

   localparam int unsigned LW   = $clog2(MAX_SYM + 1);
   localparam int unsigned UMAX = ucnt_max(WORD_GAP_UNITS, ERASE_UNITS);
   localparam int unsigned UW   = ucnt_width(WORD_GAP_UNITS, ERASE_UNITS);

   logic [UW-1:0] ucnt;
   logic          unit_tick_c;
   logic          key_edge_c;

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .UCNT_MAX    (UMAX),
      .UW          (UW)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key),
      .ucnt        (ucnt),
      .unit_tick_c (unit_tick_c),
      .key_edge_c  (key_edge_c)
   );

   logic [1:0]         state_q, state_d;
   logic [LW-1:0]      len_q, len_d;
   logic [MAX_SYM-1:0] pat_q, pat_d;

   logic               out_valid_q, out_valid_d;
   logic [1:0]         out_type_q, out_type_d;
   logic [LW-1:0]      out_len_q, out_len_d;
   logic [MAX_SYM-1:0] out_pat_q, out_pat_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic               emit_c;
   logic [1:0]         emit_type_c;
   logic [LW-1:0]      emit_len_c;
   logic [MAX_SYM-1:0] emit_pat_c;
   logic               ovf_c;
   logic               dash_c;
   logic               char_tick_c;
   logic               word_tick_c;

   // Gap ticks fire on the unit edge where ucnt is about to reach the threshold.
   always_comb begin
      dash_c      = (ucnt >= UW'(DASH_UNITS));
      char_tick_c = unit_tick_c && (ucnt == UW'(CHAR_GAP_UNITS - 1));
      word_tick_c = unit_tick_c && (ucnt == UW'(WORD_GAP_UNITS - 1));
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      pat_d       = pat_q;
      emit_c      = 1'b0;
      emit_type_c = TOK_CHAR;
      emit_len_c  = '0;
      emit_pat_c  = '0;
      ovf_c       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key) state_d = ST_MARK;
         end
         ST_MARK: begin
            if (!key) begin
               if (ucnt >= UW'(ERASE_UNITS)) begin
                  len_d       = '0;
                  pat_d       = '0;
                  emit_c      = 1'b1;
                  emit_type_c = TOK_BSP;
                  state_d     = ST_IDLE;
               end else if (len_q == LW'(MAX_SYM)) begin
                  len_d   = '0;
                  pat_d   = '0;
                  ovf_c   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pat_d   = pat_q | (MAX_SYM'(dash_c) << len_q);
                  len_d   = len_q + LW'(1);
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (key) begin
               state_d = ST_MARK;
            end else if (char_tick_c) begin
               emit_c      = 1'b1;
               emit_type_c = TOK_CHAR;
               emit_len_c  = len_q;
               emit_pat_c  = pat_q;
               len_d       = '0;
               pat_d       = '0;
               state_d     = ST_WAIT_WORD;
            end
         end
         ST_WAIT_WORD: begin
            if (key) begin
               state_d = ST_MARK;
            end else if (word_tick_c) begin
               emit_c      = 1'b1;
               emit_type_c = TOK_SPACE;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Disable abandons the character in progress but never touches the output slot.
      if (!en) begin
         state_d = ST_IDLE;
         len_d   = '0;
         pat_d   = '0;
         emit_c  = 1'b0;
         ovf_c   = 1'b0;
      end
   end

   // One-deep output slot; a new token may replace one leaving in the same cycle.
   always_comb begin
      out_valid_d = out_valid_q;
      out_type_d  = out_type_q;
      out_len_d   = out_len_q;
      out_pat_d   = out_pat_q;
      err_d       = ovf_c;
      busy_d      = (state_d != ST_IDLE);
      if (emit_c) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_type_d  = emit_type_c;
            out_len_d   = emit_len_c;
            out_pat_d   = emit_pat_c;
         end else begin
            err_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         pat_q       <= '0;
         out_valid_q <= 1'b0;
         out_type_q  <= TOK_CHAR;
         out_len_q   <= '0;
         out_pat_q   <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         pat_q       <= pat_d;
         out_valid_q <= out_valid_d;
         out_type_q  <= out_type_d;
         out_len_q   <= out_len_d;
         out_pat_q   <= out_pat_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_type    = out_type_q;
   assign out_len     = out_len_q;
   assign out_pattern = out_pat_q;
   assign err         = err_q;
   assign busy        = busy_q;

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Parametrised successor to the texter's Morse keying control FSM.
- Times a single debounced straight-key input against an internal unit prescaler and classifies each press as a dit, a dash or an erase.
- Accumulates symbols into a per-character pattern and detects character and word gaps.
- Emits character, space and backspace tokens through a valid/ready output port to the downstream character decoder and text buffer.

Parameters:
- UNIT_CYCLES, 16: clk cycles per Morse unit (>=2).
- DASH_UNITS, 2: press of >= this many whole units is a dash, else a dit.
- CHAR_GAP_UNITS, 3: key-up units ending a character.
- WORD_GAP_UNITS, 7: key-up units, counted from release, ending a word (> CHAR_GAP_UNITS).
- ERASE_UNITS, 10: press of >= this many units is an erase (> DASH_UNITS).
- MAX_SYM, 6: maximum symbols per character.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  1  synchronous, debounced key; 1 = pressed.
- en  in  1  decoder enable; 0 = synchronous clear of the FSM.
- out_valid  out  1  token available.
- out_ready  in  1  consumer accepts the token when out_valid=1.
- out_type  out  2  0 = char, 1 = space, 2 = backspace.
- out_len  out  $clog2(MAX_SYM+1)  symbol count (char only; 0 otherwise).
- out_pattern  out  MAX_SYM  bit i = symbol i, 1 = dash; first symbol at bit 0; unused bits 0.
- err  out  1  one-cycle pulse: symbol overflow or dropped token.
- busy  out  1  1 whenever the FSM state is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE; pcnt, ucnt, symbol buffer and length all cleared.
  - out_valid = 0, out_type = 0, out_len = 0, out_pattern = 0, err = 0, busy = 0.
  - Reset mid-press discards the partial character; nothing is emitted.
- Timer:
  - Any key edge (key differs from its registered previous value) clears pcnt and ucnt.
  - Otherwise pcnt increments each cycle. At UNIT_CYCLES-1 it wraps to 0 and ucnt increments, saturating at max(WORD_GAP_UNITS, ERASE_UNITS).
- States: IDLE, MARK, GAP, WAIT_WORD.
  - IDLE: key=1 -> MARK.
  - MARK, on key=0, using the ucnt value at release:
    - ucnt >= ERASE_UNITS: clear buffer, emit backspace, -> IDLE.
    - else if len == MAX_SYM: pulse err, clear buffer, -> IDLE; no char is emitted.
    - else: store the symbol at bit len (dash if ucnt >= DASH_UNITS), len+1, -> GAP.
  - GAP:
    - key=1 -> MARK.
    - On the tick where ucnt reaches CHAR_GAP_UNITS: emit char {len, pattern}, clear buffer, -> WAIT_WORD.
  - WAIT_WORD:
    - key=1 -> MARK, starting a new character.
    - On the tick where ucnt reaches WORD_GAP_UNITS: emit space, -> IDLE.
    - ucnt is not cleared between GAP and WAIT_WORD.
- en=0: state -> IDLE and buffer cleared on the next edge; a pending output token is preserved.
- Output register:
  - One entry deep. An emit loads it and out_valid rises on the next clk edge.
  - Fields stay stable while out_valid=1 and out_ready=0.
  - Handshake completes on a clk edge with out_valid=1 and out_ready=1.
  - If an emit coincides with a handshake completing, the new token is loaded and out_valid stays 1.
  - An emit while the register is full and not being accepted drops the new token and pulses err; the held token is unchanged.
- Simultaneous events: a key press in the same cycle as a gap tick takes priority; the FSM goes to MARK and no emit occurs.

Decomposition:
- Package morse_pkg:
  - out_type constants TOK_CHAR = 0, TOK_SPACE = 1, TOK_BSP = 2.
  - FSM state encoding.
  - Function computing the ucnt width from the parameters.
- Sub-module morse_unit_timer:
  - Holds pcnt, ucnt, key edge detect and saturation.
  - Outputs ucnt, unit_tick and key_edge.

Test Plan:
All scenarios use UNIT_CYCLES=4, DASH_UNITS=2, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, ERASE_UNITS=10, MAX_SYM=6, and out_ready=1 unless stated.
- key high 5 cycles, then low 40 -> char len=1 pattern=6'b000000, then space 4 units later; busy=0 at end.
- dit 5 cycles, gap 5, dash 13 cycles, then release with out_ready=0 for 10 cycles -> char len=2 pattern=6'b000010, held stable until accepted.
- 7 dits separated by 1-unit gaps -> err pulse on the 7th release; no char token; FSM in IDLE.
- key high 44 cycles -> backspace token (type=2, len=0, pattern=0), no space afterwards.
- rst_n low for 2 cycles during a dash press -> out_valid=0 immediately; a following single dit yields exactly one char len=1.
- out_ready=0 held while a char and then a space are emitted -> space dropped with an err pulse; char still presented and accepted once out_ready=1.
